// File: rtl/sm3_pkg.sv
// Shared types and helpers for the SM3 message-expansion scheduler.
// Holds the scheduler FSM states, block geometry, rotation amounts and the 32-bit rotate.
package sm3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } sm3_state_e;

  localparam int SM3_BLK_WORDS = 16;
  localparam int SM3_EXP_PAIRS = 64;
  localparam int SM3_ROT_A     = 15;
  localparam int SM3_ROT_B     = 7;

  function automatic logic [31:0] rol32(input logic [31:0] x, input int unsigned s);
    return (x << s) | (x >> (32 - s));
  endfunction

endpackage

// File: rtl/ssm3.sv
// Lightweight SM3 permutation unit: P0 or P1 of a single 32-bit word.
// Returns zero when neither permutation is selected.
module ssm3
  import sm3_pkg::*;
(
  input  logic [31:0] rs1,
  input  logic        p0,
  input  logic        p1,
  output logic [31:0] result
);

  // Select between the two SM3 linear permutations
  always_comb begin
    result = 32'd0;
    if (p1) begin
      result = rs1 ^ rol32(rs1, 15) ^ rol32(rs1, 23);
    end else if (p0) begin
      result = rs1 ^ rol32(rs1, 9) ^ rol32(rs1, 17);
    end else begin
      result = 32'd0;
    end
  end

endmodule

// File: rtl/sm3_msg_sched.sv
// SM3 message-expansion scheduler: loads 16 words, then streams 64 (W_j, W'_j) pairs
// from a 16-word sliding window, one pair per accepted cycle.
module sm3_msg_sched
  import sm3_pkg::*;
(
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_w,
  output logic [31:0] out_w1,
  output logic [5:0]  out_idx,
  output logic        out_last,
  output logic        busy
);

  sm3_state_e  state_q;
  logic [3:0]  cnt_q;
  logic [5:0]  idx_q;
  logic        in_ready_q;
  logic        out_valid_q;
  logic        last_q;
  logic        busy_q;
  logic [31:0] win_q [0:15];
  logic [31:0] w1_q;

  logic        in_hs_s;
  logic        out_hs_s;
  logic        shift_en_s;
  logic [31:0] shift_word_s;
  logic [31:0] p1_in_s;
  logic [31:0] p1_out_s;
  logic [31:0] next_w_s;

  // W_{j+16} from the current window; P1 itself comes from the shared permutation unit
  always_comb begin
    p1_in_s      = win_q[0] ^ win_q[7] ^ rol32(win_q[13], SM3_ROT_A);
    next_w_s     = p1_out_s ^ rol32(win_q[3], SM3_ROT_B) ^ win_q[10];
    in_hs_s      = in_valid & in_ready_q;
    out_hs_s     = out_valid_q & out_ready;
    shift_en_s   = in_hs_s | out_hs_s;
    shift_word_s = out_valid_q ? next_w_s : in_data;
  end

  ssm3 u_p1 (
    .rs1    (p1_in_s),
    .p0     (1'b0),
    .p1     (1'b1),
    .result (p1_out_s)
  );

  // Sliding window; W'_j is kept registered alongside so it tracks win[0]^win[4]
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      for (int k = 0; k < SM3_BLK_WORDS; k++) win_q[k] <= 32'd0;
      w1_q <= 32'd0;
    end else if (!flush && shift_en_s) begin
      for (int k = 0; k < SM3_BLK_WORDS - 1; k++) win_q[k] <= win_q[k+1];
      win_q[15] <= shift_word_s;
      w1_q      <= win_q[1] ^ win_q[5];
    end
  end

  // Block sequencing with registered handshake/status outputs
  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= 6'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      idx_q       <= 6'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_hs_s) begin
            state_q <= ST_LOAD;
            cnt_q   <= 4'd1;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (in_hs_s) begin
            if (cnt_q == 4'(SM3_BLK_WORDS - 1)) begin
              state_q     <= ST_RUN;
              cnt_q       <= 4'd0;
              idx_q       <= 6'd0;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 4'd1;
            end
          end
        end
        ST_RUN: begin
          if (out_hs_s) begin
            if (idx_q == 6'(SM3_EXP_PAIRS - 1)) begin
              state_q     <= ST_IDLE;
              idx_q       <= 6'd0;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              last_q      <= 1'b0;
              busy_q      <= 1'b0;
            end else begin
              idx_q  <= idx_q + 6'd1;
              last_q <= (idx_q == 6'(SM3_EXP_PAIRS - 2));
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          cnt_q       <= 4'd0;
          idx_q       <= 6'd0;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          last_q      <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_w     = win_q[0];
  assign out_w1    = w1_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_sm3_msg_sched.sv
// Self-checking bench for sm3_msg_sched: reference expansion computed with the plain
// SM3 recurrence over W_0..W_67, compared on every cycle a pair is presented.
module tb_sm3_msg_sched;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_w;
  logic [31:0] out_w1;
  logic [5:0]  out_idx;
  logic        out_last;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          exp_idx = 0;
  bit          chk_on = 1'b0;
  logic [31:0] mw     [0:67];
  logic [31:0] got_w  [0:63];
  logic [31:0] got_w1 [0:63];
  logic [31:0] blk    [16];

  sm3_msg_sched dut (
    .g_clk     (g_clk),
    .g_resetn  (g_resetn),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_w     (out_w),
    .out_w1    (out_w1),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 g_clk = ~g_clk;

  function automatic logic [31:0] rol(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction

  function automatic logic [31:0] p1m(input logic [31:0] x);
    return x ^ rol(x, 15) ^ rol(x, 23);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  task automatic set_model(input logic [31:0] b [16]);
    for (int i = 0; i < 16; i++) mw[i] = b[i];
    for (int n = 16; n < 68; n++)
      mw[n] = p1m(mw[n-16] ^ mw[n-9] ^ rol(mw[n-3], 15)) ^ rol(mw[n-13], 7) ^ mw[n-6];
    exp_idx = 0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_out_idx"},   {26'd0, out_idx},   32'd0);
    chk({tag, "_out_last"},  {31'd0, out_last},  32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
    chk({tag, "_out_w"},     out_w,              32'd0);
    chk({tag, "_out_w1"},    out_w1,             32'd0);
  endtask

  // Drives the first n words of b, with occasional idle gaps between them
  task automatic load_words(input logic [31:0] b [16], input int n);
    int cyc;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin @(posedge g_clk); #1; end
      in_valid = 1'b1;
      in_data  = b[i];
      cyc = 0;
      while (!in_ready && cyc < 100) begin @(posedge g_clk); #1; cyc++; end
      if (!in_ready) chk("in_ready_timeout", 32'd0, 32'd1);
      @(posedge g_clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Drains the 64 pairs; bp selects random backpressure, junk in_valid is offered meanwhile
  task automatic run_block(input bit bp);
    int cyc;
    cyc = 0;
    chk("first_valid_latency", {31'd0, out_valid}, 32'd1);
    while (exp_idx < 64 && cyc < 1000) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid  = (exp_idx < 60);
      in_data   = $urandom;
      @(posedge g_clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    chk("drain_count", exp_idx, 32'd64);
    chk("in_ready_after_block", {31'd0, in_ready}, 32'd1);
    chk("busy_after_block", {31'd0, busy}, 32'd0);
  endtask

  task automatic run_full(input logic [31:0] b [16], input bit bp);
    set_model(b);
    load_words(b, 16);
    run_block(bp);
  endtask

  // Compare process: every presented pair is checked against the reference expansion
  always @(negedge g_clk) begin
    if (chk_on && out_valid) begin
      if (exp_idx > 63) begin
        total++;
        bad++;
        $display("FAIL extra_pair: got idx %0d expected no output", out_idx);
      end else begin
        chk("idx",  {26'd0, out_idx}, exp_idx);
        chk("w",    out_w,  mw[exp_idx]);
        chk("w1",   out_w1, mw[exp_idx] ^ mw[exp_idx+4]);
        chk("last", {31'd0, out_last}, (exp_idx == 63) ? 32'd1 : 32'd0);
        chk("in_ready_in_run", {31'd0, in_ready}, 32'd0);
        chk("busy_in_run", {31'd0, busy}, 32'd1);
        got_w[exp_idx]  = out_w;
        got_w1[exp_idx] = out_w1;
        if (out_ready) exp_idx++;
      end
    end
  end

  initial begin
    int cyc;
    g_resetn  = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    repeat (3) @(posedge g_clk);
    #1;
    check_reset_vals("rst_held");
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    check_reset_vals("rst_released");
    chk_on = 1'b1;

    // All-zero block
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    run_full(blk, 1'b0);
    chk("zero_w63", got_w[63], 32'd0);

    // Single bit in W_0
    blk[0] = 32'h0000_0001;
    run_full(blk, 1'b0);
    chk("w0bit_w0",   got_w[0],   32'h0000_0001);
    chk("w0bit_w1_0", got_w1[0],  32'h0000_0001);
    chk("w0bit_w16",  got_w[16],  32'h0080_8001);

    // Rotate-7 path through W_3
    blk[0] = 32'd0;
    blk[3] = 32'h0000_0001;
    run_full(blk, 1'b1);
    chk("w3bit_w16", got_w[16], 32'h0000_0080);

    // "abc" padded block
    for (int i = 0; i < 16; i++) blk[i] = 32'd0;
    blk[0]  = 32'h6162_6380;
    blk[15] = 32'h0000_0018;
    run_full(blk, 1'b1);
    chk("abc_w1_0", got_w1[0], 32'h6162_6380);
    chk("abc_w16",  got_w[16], 32'h9092_e200);
    chk("abc_w18",  got_w[18], 32'h000c_0606);
    chk("abc_w19",  got_w[19], 32'h719c_70ed);

    // Random blocks, with and without backpressure
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) blk[i] = $urandom;
      run_full(blk, k[0]);
    end

    // flush while presenting idx 30
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    set_model(blk);
    load_words(blk, 16);
    out_ready = 1'b1;
    cyc = 0;
    while (exp_idx < 30 && cyc < 200) begin @(negedge g_clk); #1; cyc++; end
    chk("flush_reach_idx", exp_idx, 32'd30);
    @(posedge g_clk); #1;
    chk("flush_at_idx", {26'd0, out_idx}, 32'd30);
    flush = 1'b1;
    @(posedge g_clk); #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'd0, in_ready},  32'd1);
    chk("flush_busy",      {31'd0, busy},      32'd0);
    chk("flush_out_idx",   {26'd0, out_idx},   32'd0);

    // flush wins over a simultaneous input handshake in IDLE
    in_valid = 1'b1;
    in_data  = 32'hdead_beef;
    flush    = 1'b1;
    @(posedge g_clk); #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_vs_hs_busy", {31'd0, busy}, 32'd0);

    // Asynchronous reset after 8 words of a block
    for (int i = 0; i < 16; i++) blk[i] = $urandom | 32'h0000_0001;
    load_words(blk, 8);
    chk("partial_busy", {31'd0, busy}, 32'd1);
    g_resetn = 1'b0;
    #1;
    check_reset_vals("async_rst");
    #2;
    g_resetn = 1'b1;
    @(posedge g_clk); #1;
    check_reset_vals("after_async_rst");

    // Full block after the aborted one
    for (int i = 0; i < 16; i++) blk[i] = $urandom;
    run_full(blk, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
